// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RES_LT = 2'd0,
        RES_EQ = 2'd1,
        RES_GT = 2'd2
    } res_e;

    // Offset-binary mapping: flipping the sign bit turns a two's-complement
    // compare into an unsigned one; only the top slice carries that bit.
    function automatic logic offset_msb(input logic msb, input logic is_signed);
        return msb ^ is_signed;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational CHUNK-bit unsigned compare; generalisation of the old 4-bit A>=B block.
module cmp_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_slice,
    input  logic [CHUNK-1:0] b_slice,
    output logic             slice_gt,
    output logic             slice_eq
);

    assign slice_gt = (a_slice > b_slice);
    assign slice_eq = (a_slice == b_slice);

endmodule

// File: rtl/cmp_mag_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator, MSB slice first, CHUNK bits per clock.
// Optional feature: define CMP_EARLY_EXIT_EN to finish on the first differing slice.
module cmp_mag_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             ge,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NSLICE - 1);
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

`ifdef CMP_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    state_e            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              decided_q;
    res_e              res_q;
    logic              busy_q;
    logic              done_q;
    logic              ge_q;
    logic              gt_q;
    logic              eq_q;
    logic              lt_q;

    logic [WIDTH-1:0]  a_off_s;
    logic [WIDTH-1:0]  b_off_s;
    logic [CHUNK-1:0]  slice_a_s;
    logic [CHUNK-1:0]  slice_b_s;
    logic              slice_gt_s;
    logic              slice_eq_s;
    res_e              cur_res_s;
    logic              finish_s;

    // Operands are stored already offset-mapped so RUN only does unsigned slice compares.
    always_comb begin
        a_off_s            = a;
        b_off_s            = b;
        a_off_s[WIDTH-1]   = offset_msb(a[WIDTH-1], is_signed);
        b_off_s[WIDTH-1]   = offset_msb(b[WIDTH-1], is_signed);
    end

    // Select the slice currently under examination.
    always_comb begin
        slice_a_s = a_q[int'(idx_q) * CHUNK +: CHUNK];
        slice_b_s = b_q[int'(idx_q) * CHUNK +: CHUNK];
    end

    cmp_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_slice  (slice_a_s),
        .b_slice  (slice_b_s),
        .slice_gt (slice_gt_s),
        .slice_eq (slice_eq_s)
    );

    // Running verdict: the first differing slice wins and later slices are ignored.
    always_comb begin
        cur_res_s = RES_EQ;
        if (decided_q) begin
            cur_res_s = res_q;
        end else if (slice_eq_s) begin
            cur_res_s = RES_EQ;
        end else if (slice_gt_s) begin
            cur_res_s = RES_GT;
        end else begin
            cur_res_s = RES_LT;
        end
        finish_s = (idx_q == IDX_ZERO) || (EARLY_EXIT && !slice_eq_s);
    end

    // Control FSM with registered handshake and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= IDX_ZERO;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            decided_q <= 1'b0;
            res_q     <= RES_EQ;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ge_q      <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q       <= a_off_s;
                        b_q       <= b_off_s;
                        idx_q     <= IDX_TOP;
                        decided_q <= 1'b0;
                        res_q     <= RES_EQ;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (finish_s) begin
                        gt_q    <= (cur_res_s == RES_GT);
                        eq_q    <= (cur_res_s == RES_EQ);
                        lt_q    <= (cur_res_s == RES_LT);
                        ge_q    <= (cur_res_s != RES_LT);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q     <= idx_q - IDX_ONE;
                        decided_q <= decided_q | ~slice_eq_s;
                        res_q     <= cur_res_s;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ge   = ge_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_cmp_mag_seq.sv
// Scoreboard bench for cmp_mag_seq (WIDTH=16, CHUNK=4); honours CMP_EARLY_EXIT_EN.
module tb_cmp_mag_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done, ge, gt, eq, lt;

    cmp_mag_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done),
        .ge(ge), .gt(gt), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] flags;   // {gt, eq, lt}
        int         lat;
        int         acc_cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_lat(input logic [15:0] av, input logic [15:0] bv);
`ifdef CMP_EARLY_EXIT_EN
        logic [15:0] x;
        x = av ^ bv;
        for (int i = 3; i >= 0; i--) begin
            if (x[i*4 +: 4] != 4'h0) return 4 - i;
        end
        return 4;
`else
        return 4;
`endif
    endfunction

    function automatic logic [2:0] ref_flags(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        logic g, e;
        e = (av == bv);
        g = sv ? ($signed(av) > $signed(bv)) : (av > bv);
        return {g, e, !g && !e};
    endfunction

    // Scoreboard monitor: each done pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_flags"}, int'({gt, eq, lt}), int'(e.flags));
                    chk({e.name, "_ge"}, int'(ge), int'(e.flags[2] | e.flags[1]));
                    chk({e.name, "_lat"}, cyc - e.acc_cyc, e.lat);
                    chk({e.name, "_busy_low"}, int'(busy), 0);
                end
            end
        end
    end

    task automatic issue(input bit sync, input string name, input logic [15:0] av,
                         input logic [15:0] bv, input logic sv,
                         input logic [2:0] fl, input int lat);
        exp_t e;
        if (sync) @(negedge clk);
        start = 1'b1; a = av; b = bv; is_signed = sv;
        @(posedge clk); #1;
        start = 1'b0;
        e.flags = fl; e.lat = lat; e.acc_cyc = cyc; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs;

        #12; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", int'({busy, done, ge, gt, eq, lt}), 0);

        // Equal operands: eq, busy high for 4 cycles, latency 4.
        issue(1'b1, "eq1234", 16'h1234, 16'h1234, 1'b0, 3'b010, 4);
        chk("eq_busy0", int'(busy), 1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk("eq_busy", int'(busy), 1);
        end
        wait_done("eq1234");

        // Flags hold across the next accept.
        issue(1'b1, "u8000", 16'h8000, 16'h7FFF, 1'b0, 3'b100, ref_lat(16'h8000, 16'h7FFF));
        chk("hold_eq", int'({gt, eq, lt}), 3'b010);
        wait_done("u8000");
        issue(1'b1, "s8000", 16'h8000, 16'h7FFF, 1'b1, 3'b001, ref_lat(16'h8000, 16'h7FFF));
        wait_done("s8000");
        issue(1'b1, "f000", 16'hF000, 16'h0000, 1'b0, 3'b100,
`ifdef CMP_EARLY_EXIT_EN
              1
`else
              4
`endif
        );
        wait_done("f000");
        issue(1'b1, "sneg", 16'hFFFE, 16'hFFFF, 1'b1, 3'b001, ref_lat(16'hFFFE, 16'hFFFF));
        wait_done("sneg");
        issue(1'b1, "spos_neg", 16'h0001, 16'hFFFF, 1'b1, 3'b100, ref_lat(16'h0001, 16'hFFFF));
        wait_done("spos_neg");

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(1'b1, "busy_ign", 16'h0001, 16'h0002, 1'b0, 3'b001, 4);
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_ign_busy", int'(busy), 1);
        wait_done("busy_ign");
        issue(1'b0, "done_acc", 16'h00FF, 16'h00FF, 1'b0, 3'b010, 4);
        chk("done_acc_busy", int'(busy), 1);
        wait_done("done_acc");

        // Asynchronous reset mid-compare: no done afterwards.
        @(negedge clk);
        start = 1'b1; a = 16'h5555; b = 16'h5555; is_signed = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("async_rst", int'({busy, done, ge, gt, eq, lt}), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_no_done", int'(done | busy), 0);
        issue(1'b1, "post_rst", 16'h7000, 16'h7001, 1'b0, 3'b001, 4);
        wait_done("post_rst");

        // Reference-model sweep.
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = (n % 4 == 0) ? ra : ((n % 4 == 1) ? (ra ^ (16'h1 << (n % 16))) : 16'($urandom));
            rs = 1'($urandom);
            issue(1'b1, "sweep", ra, rb, rs, ref_flags(ra, rb, rs), ref_lat(ra, rb));
            wait_done("sweep");
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
